// File: rtl/mem_int.sv
// Query-driven database scanner: streams DDR bursts, scores every 512-bit beat
// against a latched 256-nucleotide query and reports the latest hit address range.
module mem_int #(
  parameter int          DDR_ADDR_WIDTH = 32,
  parameter logic [31:0] DB_START       = 32'h0000_0000,
  parameter logic [31:0] DB_END         = 32'h0010_0000,
  parameter int          THRESHOLD      = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [511:0]              query,
  input  logic                      queryValid,
  output logic                      ddr_rd,
  output logic [DDR_ADDR_WIDTH-1:0] readAdd,
  input  logic                      ddr_rd_valid,
  input  logic [511:0]              ddr_rd_data,
  input  logic                      ddr_rd_done,
  output logic [31:0]               locationStart,
  output logic [31:0]               locationEnd,
  output logic                      hitTEST
);

  localparam logic [8:0]  THR       = 9'(THRESHOLD);
  localparam logic [31:0] BEAT_SIZE = 32'd64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state_r;
  state_t       state_nx_s;
  logic         load_s;
  logic         beat_s;
  logic [511:0] query_r;
  logic [31:0]  addr_r;
  logic [31:0]  beat_addr_r;
  logic [8:0]   score_r;
  logic         score_vld_r;
  logic [31:0]  score_addr_r;
  logic         ddr_rd_r;
  logic [31:0]  loc_start_r;
  logic [31:0]  loc_end_r;
  logic         hit_r;

  function automatic logic [8:0] match_count(input logic [511:0] a, input logic [511:0] b);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < 256; i++) begin
      cnt = cnt + {8'd0, (a[2*i +: 2] == b[2*i +: 2])};
    end
    return cnt;
  endfunction

  // Next-state decode; beats are only accepted while a burst is open (REQ/DATA)
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    beat_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (queryValid) begin
          state_nx_s = REQ;
          load_s     = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      REQ: begin
        beat_s = ddr_rd_valid;
        if (ddr_rd_done) begin
          state_nx_s = NEXT;
        end else if (ddr_rd_valid) begin
          state_nx_s = DATA;
        end else begin
          state_nx_s = REQ;
        end
      end
      DATA: begin
        beat_s = ddr_rd_valid;
        if (ddr_rd_done) begin
          state_nx_s = NEXT;
        end else begin
          state_nx_s = DATA;
        end
      end
      NEXT: begin
        if (beat_addr_r >= DB_END) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = REQ;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control registers: state, request level and burst/beat addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ddr_rd_r    <= 1'b0;
      addr_r      <= 32'd0;
      beat_addr_r <= 32'd0;
      query_r     <= 512'd0;
    end else begin
      state_r  <= state_nx_s;
      ddr_rd_r <= (state_nx_s == REQ);
      if (load_s) begin
        query_r     <= query;
        addr_r      <= DB_START;
        beat_addr_r <= DB_START;
      end else begin
        if (state_r == NEXT) begin
          addr_r <= beat_addr_r;
        end
        if (beat_s) begin
          beat_addr_r <= beat_addr_r + BEAT_SIZE;
        end
      end
    end
  end

  // Score stage: one registered match count per accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_r      <= 9'd0;
      score_vld_r  <= 1'b0;
      score_addr_r <= 32'd0;
    end else begin
      score_vld_r <= beat_s & ~load_s;
      if (beat_s) begin
        score_r      <= match_count(query_r, ddr_rd_data);
        score_addr_r <= beat_addr_r;
      end
    end
  end

  // Hit reporting; a new query clears the sticky flag and the location
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loc_start_r <= 32'd0;
      loc_end_r   <= 32'd0;
      hit_r       <= 1'b0;
    end else if (load_s) begin
      loc_start_r <= 32'd0;
      loc_end_r   <= 32'd0;
      hit_r       <= 1'b0;
    end else if (score_vld_r && (score_r >= THR)) begin
      loc_start_r <= score_addr_r;
      loc_end_r   <= score_addr_r + 32'd63;
      hit_r       <= 1'b1;
    end
  end

  assign ddr_rd        = ddr_rd_r;
  assign readAdd       = DDR_ADDR_WIDTH'(addr_r);
  assign locationStart = loc_start_r;
  assign locationEnd   = loc_end_r;
  assign hitTEST       = hit_r;

endmodule

// File: tb/tb_mem_int.sv
// Directed bench for mem_int: small database (8 beats) so full scans stay short.
module tb_mem_int;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] query;
  logic         queryValid;
  logic         ddr_rd;
  logic [31:0]  readAdd;
  logic         ddr_rd_valid;
  logic [511:0] ddr_rd_data;
  logic         ddr_rd_done;
  logic [31:0]  locationStart;
  logic [31:0]  locationEnd;
  logic         hitTEST;

  int vectors     = 0;
  int miscompares = 0;

  logic [511:0] q1, q2, d200, d199;

  mem_int #(
    .DDR_ADDR_WIDTH(32),
    .DB_START      (32'h0000_0000),
    .DB_END        (32'h0000_0200),
    .THRESHOLD     (200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .query        (query),
    .queryValid   (queryValid),
    .ddr_rd       (ddr_rd),
    .readAdd      (readAdd),
    .ddr_rd_valid (ddr_rd_valid),
    .ddr_rd_data  (ddr_rd_data),
    .ddr_rd_done  (ddr_rd_done),
    .locationStart(locationStart),
    .locationEnd  (locationEnd),
    .hitTEST      (hitTEST)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    q1 = 512'hFFF;
    q2 = 512'h5;
    for (int i = 0; i < 256; i++) begin
      d200[2*i +: 2] = (i < 56) ? ~q1[2*i +: 2] : q1[2*i +: 2];
      d199[2*i +: 2] = (i < 57) ? ~q1[2*i +: 2] : q1[2*i +: 2];
    end

    rst          = 1'b0;
    query        = 512'd0;
    queryValid   = 1'b0;
    ddr_rd_valid = 1'b0;
    ddr_rd_data  = 512'd0;
    ddr_rd_done  = 1'b0;
    #1;
    chk("rst_ddr_rd", 32'(ddr_rd), 32'd0);
    chk("rst_readAdd", readAdd, 32'd0);
    chk("rst_locStart", locationStart, 32'd0);
    chk("rst_locEnd", locationEnd, 32'd0);
    chk("rst_hit", 32'(hitTEST), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk("idle_no_rd", 32'(ddr_rd), 32'd0);

    // query 512'hFFF: request one cycle later, held until first valid
    query = q1; queryValid = 1'b1;
    cyc(1);
    queryValid = 1'b0;
    chk("q1_rd", 32'(ddr_rd), 32'd1);
    chk("q1_addr", readAdd, 32'd0);
    cyc(3);
    chk("q1_rd_held", 32'(ddr_rd), 32'd1);

    // three beats of 512'h11 (score 250), done with the third
    ddr_rd_valid = 1'b1; ddr_rd_data = 512'h11;
    cyc(1);
    chk("b0_rd_drop", 32'(ddr_rd), 32'd0);
    chk("b0_hit_latency", 32'(hitTEST), 32'd0);
    cyc(1);
    chk("b0_hit", 32'(hitTEST), 32'd1);
    chk("b0_locStart", locationStart, 32'd0);
    ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
    chk("b1_locStart", locationStart, 32'd64);
    chk("next_rd_low", 32'(ddr_rd), 32'd0);
    cyc(1);
    chk("b2_locStart", locationStart, 32'd128);
    chk("b2_locEnd", locationEnd, 32'd191);
    chk("turn_rd", 32'(ddr_rd), 32'd1);
    chk("turn_addr", readAdd, 32'd192);

    // threshold boundary: 200 matches hits, 199 does not
    ddr_rd_valid = 1'b1; ddr_rd_data = d200;
    cyc(1);
    ddr_rd_data = d199; ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
    chk("thr200_locStart", locationStart, 32'd192);
    chk("thr200_locEnd", locationEnd, 32'd255);
    cyc(1);
    chk("thr199_locStart", locationStart, 32'd192);
    cyc(1);
    chk("req320_rd", 32'(ddr_rd), 32'd1);
    chk("req320_addr", readAdd, 32'd320);

    // done with no beat: same address requested again
    ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_done = 1'b0;
    chk("empty_next_rd", 32'(ddr_rd), 32'd0);
    cyc(1);
    chk("empty_rereq_rd", 32'(ddr_rd), 32'd1);
    chk("empty_rereq_addr", readAdd, 32'd320);

    // last three beats (score 0); queryValid during REQ must be ignored
    ddr_rd_valid = 1'b1; ddr_rd_data = ~q1; queryValid = 1'b1; query = q2;
    cyc(1);
    queryValid = 1'b0;
    cyc(1);
    ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
    chk("qv_ignored_hit", 32'(hitTEST), 32'd1);
    cyc(1);
    chk("done_rd", 32'(ddr_rd), 32'd0);
    cyc(3);
    chk("done_rd_hold", 32'(ddr_rd), 32'd0);
    chk("done_locStart", locationStart, 32'd192);
    chk("done_hit", 32'(hitTEST), 32'd1);

    // restart from DONE with a different query
    query = q2; queryValid = 1'b1;
    cyc(1);
    queryValid = 1'b0;
    chk("q2_hit_clr", 32'(hitTEST), 32'd0);
    chk("q2_locStart_clr", locationStart, 32'd0);
    chk("q2_locEnd_clr", locationEnd, 32'd0);
    chk("q2_rd", 32'(ddr_rd), 32'd1);
    chk("q2_addr", readAdd, 32'd0);

    // score-0 beats through to the end of the database
    ddr_rd_valid = 1'b1; ddr_rd_data = ~q2;
    cyc(1);
    ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
    cyc(2);
    chk("q2_req128_rd", 32'(ddr_rd), 32'd1);
    chk("q2_req128_addr", readAdd, 32'd128);
    chk("q2_nohit_a", 32'(hitTEST), 32'd0);
    ddr_rd_valid = 1'b1;
    cyc(5);
    ddr_rd_done = 1'b1;
    cyc(1);
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
    cyc(2);
    chk("q2_done_rd", 32'(ddr_rd), 32'd0);
    chk("q2_nohit_b", 32'(hitTEST), 32'd0);
    chk("q2_locStart_0", locationStart, 32'd0);
    chk("q2_locEnd_0", locationEnd, 32'd0);

    // hit at beat 1, then asynchronous reset while in DATA
    queryValid = 1'b1;
    cyc(1);
    queryValid = 1'b0;
    chk("q3_rd", 32'(ddr_rd), 32'd1);
    ddr_rd_valid = 1'b1; ddr_rd_data = ~q2;
    cyc(1);
    ddr_rd_data = q2;
    cyc(1);
    ddr_rd_valid = 1'b0;
    cyc(1);
    chk("q3_hit", 32'(hitTEST), 32'd1);
    chk("q3_locStart", locationStart, 32'd64);
    chk("q3_locEnd", locationEnd, 32'd127);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rd", 32'(ddr_rd), 32'd0);
    chk("arst_addr", readAdd, 32'd0);
    chk("arst_locStart", locationStart, 32'd0);
    chk("arst_locEnd", locationEnd, 32'd0);
    chk("arst_hit", 32'(hitTEST), 32'd0);
    #2;
    rst = 1'b1;
    cyc(3);
    chk("arst_idle_rd", 32'(ddr_rd), 32'd0);
    query = q1; queryValid = 1'b1;
    cyc(1);
    queryValid = 1'b0;
    chk("post_rst_rd", 32'(ddr_rd), 32'd1);
    chk("post_rst_addr", readAdd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
